// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter giving two requesters one-at-a-time access
// to a single long-latency memory, with a per-transaction timeout.
module mem_port_arbiter #(
    parameter int data_width = 16,
    parameter int addr_width = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [addr_width-1:0] addr0,
    input  logic [addr_width-1:0] addr1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [data_width-1:0] wdata0,
    input  logic [data_width-1:0] wdata1,
    output logic                  ready0,
    output logic                  ready1,
    output logic [data_width-1:0] rdata0,
    output logic [data_width-1:0] rdata1,
    output logic [addr_width-1:0] mem_address,
    output logic                  mem_we,
    output logic [data_width-1:0] mem_data_write,
    input  logic                  mem_service_ready,
    input  logic [data_width-1:0] mem_data_read,
    output logic                  timeout_err
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_next;
    logic id, we_q, last_served, winner, grant, abort, capture;
    logic [CW-1:0] cnt;
    logic [data_width-1:0] rd_val;

    always_comb begin
        winner     = (req0 && req1) ? !last_served : req1;
        grant      = state == IDLE && (req0 || req1);
        abort      = state == BUSY && !mem_service_ready && cnt == CW'(TIMEOUT - 1);
        capture    = abort || (state == BUSY && mem_service_ready && !we_q);
        rd_val     = abort ? '0 : mem_data_read;
        state_next = grant ? BUSY :
                     (state == BUSY && (mem_service_ready || abort)) ? RESP :
                     state == BUSY ? BUSY : IDLE;
    end

    assign ready0 = state == RESP && !id;
    assign ready1 = state == RESP && id;
    assign mem_we = state == BUSY && we_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_next;

    // Memory-side address/data are only loaded at grant so the memory never sees them move mid-access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id             <= 1'b0;
            we_q           <= 1'b0;
            last_served    <= 1'b1;
            cnt            <= '0;
            mem_address    <= '0;
            mem_data_write <= '0;
            rdata0         <= '0;
            rdata1         <= '0;
            timeout_err    <= 1'b0;
        end else begin
            if (grant) begin
                id             <= winner;
                last_served    <= winner;
                cnt            <= '0;
                mem_address    <= winner ? addr1 : addr0;
                we_q           <= winner ? we1 : we0;
                mem_data_write <= winner ? wdata1 : wdata0;
            end
            if (state == BUSY) cnt <= cnt + 1'b1;
            if (capture && !id) rdata0 <= rd_val;
            if (capture && id) rdata1 <= rd_val;
            if (abort) timeout_err <= 1'b1;
        end
    end
endmodule
